// File: rtl/bayer_downsample_pp_if.sv
// Pixel-stream and frame-buffer read bus for bayer_downsample_pp.
// The master drives the camera stream and read address; the slave is the downsampler.
interface bayer_downsample_pp_if #(
    parameter int XW = 6,
    parameter int YW = 5
);
    logic          in_frame;
    logic          in_line;
    logic          data_enable;
    logic [31:0]   pixel_data;
    logic [XW-1:0] read_x;
    logic [YW-1:0] read_y;
    logic [31:0]   read_q;
    logic          read_bank;
    logic          frame_done;

    modport master (
        output in_frame, in_line, data_enable, pixel_data, read_x, read_y,
        input  read_q, read_bank, frame_done
    );

    modport slave (
        input  in_frame, in_line, data_enable, pixel_data, read_x, read_y,
        output read_q, read_bank, frame_done
    );
endinterface

// File: rtl/bayer_downsample_pp.sv
// RGGB Bayer box downsampler into a ping-pong RGB frame buffer with a 1-cycle read port.
// Optional build macro DOWNSAMPLE_ROUND_EN selects round-half-up averaging with saturation.
module bayer_downsample_pp #(
    parameter int IN_WIDTH   = 640,
    parameter int IN_HEIGHT  = 480,
    parameter int BLOCK_LOG2 = 4,
    parameter int XW         = 6,
    parameter int YW         = 5
) (
    input  logic                  pixel_clock,
    input  logic                  reset,
    bayer_downsample_pp_if.slave  bus
);
    localparam int OUT_W  = IN_WIDTH >> BLOCK_LOG2;
    localparam int OUT_H  = IN_HEIGHT >> BLOCK_LOG2;
    localparam int BEATS  = IN_WIDTH / 4;
    localparam int X4W    = $clog2(BEATS + 1);
    localparam int YCW    = $clog2(IN_HEIGHT + 1);
    localparam int AW     = 8 + 2 * BLOCK_LOG2;
    localparam int AW1    = AW + 1;
    localparam int SUB    = BLOCK_LOG2 - 2;
    localparam int K_RB   = 2 * BLOCK_LOG2 - 2;
    localparam int K_G    = 2 * BLOCK_LOG2 - 1;
    localparam int ACC_N  = 1 << XW;
    localparam int ADDR_W = 1 + YW + XW;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [X4W-1:0] SUB_MASK = X4W'((1 << SUB) - 1);
    localparam logic [YCW-1:0] Y_MASK   = YCW'((1 << BLOCK_LOG2) - 1);
    localparam logic [X4W-1:0] BEATS_C  = X4W'(BEATS);
    localparam logic [YCW-1:0] HEIGHT_C = YCW'(IN_HEIGHT);
    localparam logic [X4W-1:0] X4_ZERO  = {X4W{1'b0}};
    localparam logic [YCW-1:0] Y_ZERO   = {YCW{1'b0}};
    localparam logic [X4W-1:0] X4_ONE   = {{(X4W-1){1'b0}}, 1'b1};
    localparam logic [YCW-1:0] Y_ONE    = {{(YCW-1){1'b0}}, 1'b1};
    localparam logic [XW-1:0]  LAST_BX  = XW'(OUT_W - 1);
    localparam logic [YW-1:0]  LAST_BY  = YW'(OUT_H - 1);
    localparam logic [AW-1:0]  ACC_ZERO = {AW{1'b0}};

    // Block sum to 8-bit average; k is the log2 of the number of contributing sites.
    function automatic logic [7:0] avg8(input logic [AW-1:0] sum, input int k);
`ifdef DOWNSAMPLE_ROUND_EN
        logic [AW:0] t;
        t = ({1'b0, sum} + (AW1'(1'b1) << (k - 1))) >> k;
        return (t > AW1'(8'hFF)) ? 8'hFF : t[7:0];
`else
        return 8'(sum >> k);
`endif
    endfunction

    logic [X4W-1:0] x4_r;
    logic [YCW-1:0] y_r;
    logic           line_d_r;
    logic           wbank_r;
    logic           read_bank_r;
    logic           frame_done_r;
    logic [31:0]    read_q_r;

    logic [AW-1:0]  acc_r_r [ACC_N];
    logic [AW-1:0]  acc_g_r [ACC_N];
    logic [AW-1:0]  acc_b_r [ACC_N];
    logic [23:0]    mem_r   [DEPTH];

    logic           beat_s;
    logic           line_fall_s;
    logic           first_s;
    logic           commit_s;
    logic           last_blk_s;
    logic [XW-1:0]  bx_s;
    logic [YW-1:0]  by_s;
    logic [8:0]     s0_s;
    logic [8:0]     s1_s;
    logic [AW-1:0]  base_r_s, base_g_s, base_b_s;
    logic [AW-1:0]  sum_r_s, sum_g_s, sum_b_s;
    logic [23:0]    avg_s;

    // Beat qualification, block addressing and bypassed accumulator sums.
    always_comb begin
        s0_s = {1'b0, bus.pixel_data[7:0]}  + {1'b0, bus.pixel_data[23:16]};
        s1_s = {1'b0, bus.pixel_data[15:8]} + {1'b0, bus.pixel_data[31:24]};
        beat_s = ~reset & bus.in_frame & bus.in_line & bus.data_enable
               & (x4_r < BEATS_C) & (y_r < HEIGHT_C);
        line_fall_s = line_d_r & ~bus.in_line;
        bx_s = XW'(x4_r >> SUB);
        by_s = YW'(y_r >> BLOCK_LOG2);
        // The first beat of a block stands in for an explicit accumulator clear.
        first_s = ((y_r & Y_MASK) == Y_ZERO) && ((x4_r & SUB_MASK) == X4_ZERO);
        if (first_s) begin
            base_r_s = ACC_ZERO;
            base_g_s = ACC_ZERO;
            base_b_s = ACC_ZERO;
        end else begin
            base_r_s = acc_r_r[bx_s];
            base_g_s = acc_g_r[bx_s];
            base_b_s = acc_b_r[bx_s];
        end
        if (y_r[0] == 1'b0) begin
            sum_r_s = base_r_s + {{(AW-9){1'b0}}, s0_s};
            sum_g_s = base_g_s + {{(AW-9){1'b0}}, s1_s};
            sum_b_s = base_b_s;
        end else begin
            sum_r_s = base_r_s;
            sum_g_s = base_g_s + {{(AW-9){1'b0}}, s0_s};
            sum_b_s = base_b_s + {{(AW-9){1'b0}}, s1_s};
        end
        commit_s = beat_s && ((y_r & Y_MASK) == Y_MASK) && ((x4_r & SUB_MASK) == SUB_MASK);
        last_blk_s = commit_s && (bx_s == LAST_BX) && (by_s == LAST_BY);
        avg_s = {avg8(sum_r_s, K_RB), avg8(sum_g_s, K_G), avg8(sum_b_s, K_RB)};
    end

    // Beat and line position counters with in_line falling-edge detect.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            x4_r     <= X4_ZERO;
            y_r      <= Y_ZERO;
            line_d_r <= 1'b0;
        end else begin
            line_d_r <= bus.in_line;
            if (!bus.in_frame) begin
                x4_r <= X4_ZERO;
                y_r  <= Y_ZERO;
            end else begin
                if (!bus.in_line) begin
                    x4_r <= X4_ZERO;
                end else if (beat_s) begin
                    x4_r <= x4_r + X4_ONE;
                end
                if (line_fall_s && (y_r < HEIGHT_C)) begin
                    y_r <= y_r + Y_ONE;
                end
            end
        end
    end

    // Per-column accumulators; no reset needed since each block's first beat ignores them.
    always_ff @(posedge pixel_clock) begin
        if (beat_s) begin
            acc_r_r[bx_s] <= sum_r_s;
            acc_g_r[bx_s] <= sum_g_s;
            acc_b_r[bx_s] <= sum_b_s;
        end
    end

    // Frame buffer write port: both banks in one array, bank bit on top of the address.
    always_ff @(posedge pixel_clock) begin
        if (commit_s) begin
            mem_r[{wbank_r, by_s, bx_s}] <= avg_s;
        end
    end

    // Bank swap and frame_done pulse in the cycle after the final block commits.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            wbank_r      <= 1'b0;
            read_bank_r  <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= last_blk_s;
            if (last_blk_s) begin
                wbank_r     <= ~wbank_r;
                read_bank_r <= wbank_r;
            end
        end
    end

    // Registered read port into the bank holding the last complete frame.
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            read_q_r <= 32'h0000_0000;
        end else begin
            read_q_r <= {8'hFF, mem_r[{read_bank_r, bus.read_y, bus.read_x}]};
        end
    end

    assign bus.read_q     = read_q_r;
    assign bus.read_bank  = read_bank_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_bayer_downsample_pp.sv
// Randomized bench for bayer_downsample_pp on a reduced 64x32 frame with 8x8 blocks,
// checked against a pixel-level block-average model of the image that was streamed.
module tb_bayer_downsample_pp;
    localparam int IW    = 64;
    localparam int IH    = 32;
    localparam int BL    = 3;
    localparam int XW    = 3;
    localparam int YW    = 2;
    localparam int OW    = IW >> BL;
    localparam int OH    = IH >> BL;
    localparam int BEATS = IW / 4;

    logic pixel_clock = 1'b0;
    logic reset = 1'b1;
    always #5 pixel_clock = ~pixel_clock;

    bayer_downsample_pp_if #(.XW(XW), .YW(YW)) bus ();

    bayer_downsample_pp #(
        .IN_WIDTH(IW), .IN_HEIGHT(IH), .BLOCK_LOG2(BL), .XW(XW), .YW(YW)
    ) dut (
        .pixel_clock(pixel_clock),
        .reset(reset),
        .bus(bus)
    );

    logic [7:0]  img   [IH][IW];
    logic [31:0] shown [OH][OW];
    logic [31:0] got   [OH][OW];
    bit          shown_valid = 1'b0;
    logic        exp_rbank = 1'b1;
    int          total = 0;
    int          bad = 0;
    int          fd_cnt = 0;

    always @(negedge pixel_clock) begin
        if (bus.frame_done === 1'b1) fd_cnt++;
    end

    task automatic tick();
        @(posedge pixel_clock);
        #1;
    endtask

    function automatic logic [7:0] avg(int s, int k);
        int v;
`ifdef DOWNSAMPLE_ROUND_EN
        v = (s + (1 << (k - 1))) >> k;
        if (v > 255) v = 255;
`else
        v = s >> k;
`endif
        return 8'(v);
    endfunction

    // Average of each Bayer colour over the whole block, straight from the pixel image.
    function automatic logic [31:0] model_word(int by, int bx);
        int rs = 0;
        int gs = 0;
        int bs = 0;
        int n = 1 << BL;
        for (int r = by * n; r < by * n + n; r++) begin
            for (int c = bx * n; c < bx * n + n; c++) begin
                if ((r % 2 == 0) && (c % 2 == 0)) rs += int'(img[r][c]);
                else if ((r % 2 == 1) && (c % 2 == 1)) bs += int'(img[r][c]);
                else gs += int'(img[r][c]);
            end
        end
        return {8'hFF, avg(rs, 2 * BL - 2), avg(gs, 2 * BL - 1), avg(bs, 2 * BL - 2)};
    endfunction

    task automatic commit_model();
        for (int y = 0; y < OH; y++)
            for (int x = 0; x < OW; x++)
                shown[y][x] = model_word(y, x);
        shown_valid = 1'b1;
        exp_rbank = ~exp_rbank;
    endtask

    task automatic fill(int mode);
        for (int r = 0; r < IH; r++) begin
            for (int c = 0; c < IW; c++) begin
                case (mode)
                    0: img[r][c] = 8'h80;
                    1: img[r][c] = (r % 2 == 0) ? ((c % 2 == 0) ? 8'hC0 : 8'h40)
                                                : ((c % 2 == 0) ? 8'h40 : 8'h20);
                    2: img[r][c] = 8'($urandom);
                    default: img[r][c] = 8'h00;
                endcase
            end
        end
    endtask

    task automatic send_line(int row, int extra, bit gaps, bit garbage);
        bus.in_line = 1'b1;
        for (int b = 0; b < BEATS + extra; b++) begin
            if (gaps && ($urandom_range(3) == 0)) begin
                bus.data_enable = 1'b0;
                bus.pixel_data = $urandom;
                tick();
            end
            bus.data_enable = 1'b1;
            if (garbage || b >= BEATS)
                bus.pixel_data = $urandom;
            else
                bus.pixel_data = {img[row][4*b+3], img[row][4*b+2], img[row][4*b+1], img[row][4*b]};
            tick();
        end
        bus.data_enable = 1'b0;
        bus.pixel_data = $urandom;
        bus.in_line = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_frame(int nlines, int extra_beats, int extra_lines, bit gaps);
        bus.in_frame = 1'b1;
        tick();
        for (int l = 0; l < nlines; l++) send_line(l, extra_beats, gaps, 1'b0);
        for (int e = 0; e < extra_lines; e++) send_line(0, extra_beats, gaps, 1'b1);
        bus.in_frame = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic read_all();
        for (int y = 0; y < OH; y++) begin
            for (int x = 0; x < OW; x++) begin
                bus.read_x = XW'(x);
                bus.read_y = YW'(y);
                tick();
                got[y][x] = bus.read_q;
            end
        end
    endtask

    task automatic test_reset();
        int fd0;
        fd0 = fd_cnt;
        reset = 1'b1;
        bus.read_x = '0;
        bus.read_y = '0;
        tick();
        tick();
        total++;
        if (bus.read_q !== 32'h0) begin bad++; $display("FAIL reset_read_q got=%h want=00000000", bus.read_q); end
        total++;
        if (bus.read_bank !== 1'b1) begin bad++; $display("FAIL reset_read_bank got=%b want=1", bus.read_bank); end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (fd_cnt != fd0) begin bad++; $display("FAIL reset_frame_done got=%0d want=0", fd_cnt - fd0); end
        exp_rbank = 1'b1;
        shown_valid = 1'b0;
    endtask

    task automatic test_frame(string name, int mode, bit gaps);
        int fd0;
        fd0 = fd_cnt;
        fill(mode);
        if (mode == 3) begin
            img[0][0] = 8'd1;
            img[0][2] = 8'd7;
        end
        send_frame(IH, 0, 0, gaps);
        commit_model();
        read_all();
        total++;
        if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL %s_frame_done got=%0d want=1", name, fd_cnt - fd0); end
        total++;
        if (bus.read_bank !== exp_rbank) begin bad++; $display("FAIL %s_read_bank got=%b want=%b", name, bus.read_bank, exp_rbank); end
        for (int y = 0; y < OH; y++)
            for (int x = 0; x < OW; x++) begin
                total++;
                if (got[y][x] !== shown[y][x]) begin
                    bad++;
                    $display("FAIL %s_data (%0d,%0d) got=%h want=%h", name, x, y, got[y][x], shown[y][x]);
                end
            end
    endtask

    task automatic test_constants();
        test_frame("flat", 0, 1'b0);
        total++;
        if (got[OH-1][OW-1] !== 32'hFF808080) begin bad++; $display("FAIL flat_const got=%h want=FF808080", got[OH-1][OW-1]); end
        test_frame("pattern", 1, 1'b1);
        total++;
        if (got[1][2] !== 32'hFFC04020) begin bad++; $display("FAIL pattern_const got=%h want=FFC04020", got[1][2]); end
    endtask

    task automatic test_single_r();
        logic [7:0] want_r;
`ifdef DOWNSAMPLE_ROUND_EN
        want_r = 8'd1;
`else
        want_r = 8'd0;
`endif
        test_frame("single_r", 3, 1'b0);
        total++;
        if (got[0][0][23:16] !== want_r) begin bad++; $display("FAIL single_r_avg got=%h want=%h", got[0][0][23:16], want_r); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) test_frame("random", 2, 1'b1);
    endtask

    task automatic test_abort();
        int fd0;
        fd0 = fd_cnt;
        fill(2);
        send_frame(20, 0, 0, 1'b1);
        read_all();
        total++;
        if (fd_cnt != fd0) begin bad++; $display("FAIL abort_frame_done got=%0d want=0", fd_cnt - fd0); end
        total++;
        if (bus.read_bank !== exp_rbank) begin bad++; $display("FAIL abort_read_bank got=%b want=%b", bus.read_bank, exp_rbank); end
        for (int y = 0; y < OH; y++)
            for (int x = 0; x < OW; x++) begin
                total++;
                if (got[y][x] !== shown[y][x]) begin
                    bad++;
                    $display("FAIL abort_data (%0d,%0d) got=%h want=%h", x, y, got[y][x], shown[y][x]);
                end
            end
        test_frame("after_abort", 2, 1'b1);
    endtask

    task automatic test_extra();
        int fd0;
        fd0 = fd_cnt;
        fill(2);
        send_frame(IH, 3, 4, 1'b1);
        commit_model();
        read_all();
        total++;
        if (fd_cnt - fd0 != 1) begin bad++; $display("FAIL extra_frame_done got=%0d want=1", fd_cnt - fd0); end
        for (int y = 0; y < OH; y++)
            for (int x = 0; x < OW; x++) begin
                total++;
                if (got[y][x] !== shown[y][x]) begin
                    bad++;
                    $display("FAIL extra_data (%0d,%0d) got=%h want=%h", x, y, got[y][x], shown[y][x]);
                end
            end
    endtask

    task automatic test_reset_mid();
        int fd0;
        fd0 = fd_cnt;
        fill(2);
        bus.in_frame = 1'b1;
        tick();
        for (int l = 0; l < 9; l++) send_line(l, 0, 1'b0, 1'b0);
        bus.in_line = 1'b1;
        bus.data_enable = 1'b1;
        for (int b = 0; b < 5; b++) begin
            bus.pixel_data = $urandom;
            tick();
        end
        reset = 1'b1;
        tick();
        bus.in_line = 1'b0;
        bus.in_frame = 1'b0;
        bus.data_enable = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        exp_rbank = 1'b1;
        shown_valid = 1'b0;
        total++;
        if (bus.read_bank !== 1'b1) begin bad++; $display("FAIL midreset_read_bank got=%b want=1", bus.read_bank); end
        total++;
        if (fd_cnt != fd0) begin bad++; $display("FAIL midreset_frame_done got=%0d want=0", fd_cnt - fd0); end
        test_frame("after_reset", 2, 1'b1);
    endtask

    task automatic test_back_to_back();
        int fd0;
        fd0 = fd_cnt;
        fill(2);
        bus.in_frame = 1'b1;
        tick();
        for (int l = 0; l < IH; l++) send_line(l, 0, 1'b0, 1'b0);
        bus.in_frame = 1'b0;
        tick();
        commit_model();
        fill(2);
        send_frame(IH, 0, 0, 1'b0);
        commit_model();
        read_all();
        total++;
        if (fd_cnt - fd0 != 2) begin bad++; $display("FAIL b2b_frame_done got=%0d want=2", fd_cnt - fd0); end
        total++;
        if (bus.read_bank !== exp_rbank) begin bad++; $display("FAIL b2b_read_bank got=%b want=%b", bus.read_bank, exp_rbank); end
        for (int y = 0; y < OH; y++)
            for (int x = 0; x < OW; x++) begin
                total++;
                if (got[y][x] !== shown[y][x]) begin
                    bad++;
                    $display("FAIL b2b_data (%0d,%0d) got=%h want=%h", x, y, got[y][x], shown[y][x]);
                end
            end
    endtask

    initial begin
        bus.in_frame = 1'b0;
        bus.in_line = 1'b0;
        bus.data_enable = 1'b0;
        bus.pixel_data = 32'h0;
        bus.read_x = '0;
        bus.read_y = '0;
        test_reset();
        test_constants();
        test_single_r();
        test_random();
        test_abort();
        test_extra();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
